// File: rtl/sdp_ram_port_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module      : sdp_ram_port_arbiter_if                                    |
// | Description : Requester-side bus of the two-port SDP RAM arbiter.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sdp_ram_port_arbiter_if #(
  parameter int ADDRS_WIDTH = 12
);
  // Write port, two requesters packed side by side
  logic [1:0]               wr_req;
  logic [2*ADDRS_WIDTH-1:0] wr_addrs;
  logic [127:0]             wr_data;
  logic [15:0]              wr_bwren;
  logic [1:0]               wr_gnt;

  // Read port; rd_data is shared, rd_valid tags the owner
  logic [1:0]               rd_req;
  logic [2*ADDRS_WIDTH-1:0] rd_addrs;
  logic [1:0]               rd_gnt;
  logic [1:0]               rd_valid;
  logic [63:0]              rd_data;

  modport master (
    output wr_req, wr_addrs, wr_data, wr_bwren,
    input  wr_gnt,
    output rd_req, rd_addrs,
    input  rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addrs, wr_data, wr_bwren,
    output wr_gnt,
    input  rd_req, rd_addrs,
    output rd_gnt, rd_valid, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/sdp_ram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : sdp_ram_port_arbiter                                       |
// | Description : Round-robin sharing of one 64-bit SDP RAM by two clients.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sdp_ram_port_arbiter #(
  parameter int ADDRS_WIDTH = 12
) (
  input  wire                          CLK,
  input  wire                          rstb,
  sdp_ram_port_arbiter_if.slave        req_if,
  output logic                         ram_wren,
  output logic [7:0]                   ram_bwren,
  output logic [ADDRS_WIDTH-1:0]       ram_wraddrs,
  output logic [63:0]                  ram_wrdata,
  output logic                         ram_rden,
  output logic [ADDRS_WIDTH-1:0]       ram_rdaddrs,
  input  wire  [63:0]                  ram_rddata
);

  // Pointer holds the requester that wins the next tie; it flips to the
  // other side after every grant, so held requests alternate 0,1,0,1...
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = prio ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  logic [ADDRS_WIDTH-1:0] wr_addr [0:1];
  logic [ADDRS_WIDTH-1:0] rd_addr [0:1];
  logic [63:0]            wr_word [0:1];
  logic [7:0]             wr_be   [0:1];

  generate
    for (genvar r = 0; r < 2; r++) begin : g_unpack
      assign wr_addr[r] = req_if.wr_addrs[r*ADDRS_WIDTH +: ADDRS_WIDTH];
      assign rd_addr[r] = req_if.rd_addrs[r*ADDRS_WIDTH +: ADDRS_WIDTH];
      assign wr_word[r] = req_if.wr_data[r*64 +: 64];
      assign wr_be[r]   = req_if.wr_bwren[r*8 +: 8];
    end
  endgenerate

  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   ram_wren_q, ram_wren_d;
  logic [7:0]             ram_bwren_q, ram_bwren_d;
  logic [ADDRS_WIDTH-1:0] ram_wraddrs_q, ram_wraddrs_d;
  logic [63:0]            ram_wrdata_q, ram_wrdata_d;
  logic                   ram_rden_q, ram_rden_d;
  logic [ADDRS_WIDTH-1:0] ram_rdaddrs_q, ram_rdaddrs_d;
  logic [1:0]             rd_tag_q, rd_tag_d;
  logic [1:0]             rd_valid_q, rd_valid_d;

  logic [1:0]             wr_gnt;
  logic                   wr_sel;
  logic [1:0]             rd_cand;
  logic                   rd_sel;
  logic [ADDRS_WIDTH-1:0] rd_cand_addr;
  logic                   rd_hazard;
  logic [1:0]             rd_gnt;

  // The RAM is read-first, so a read that collides with the write being
  // granted now or the one still sitting on the RAM port must wait; the
  // whole read port stalls rather than letting the other requester pass.
  always_comb begin
    wr_gnt       = rstb ? 2'b00 : rr_pick(req_if.wr_req, wr_ptr_q);
    wr_sel       = wr_gnt[1];
    rd_cand      = rr_pick(req_if.rd_req, rd_ptr_q);
    rd_sel       = rd_cand[1];
    rd_cand_addr = rd_addr[rd_sel];
    rd_hazard    = ((|wr_gnt) && (rd_cand_addr == wr_addr[wr_sel])) ||
                   (ram_wren_q && (rd_cand_addr == ram_wraddrs_q));
    rd_gnt       = (rstb || rd_hazard) ? 2'b00 : rd_cand;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_wren_d    = |wr_gnt;
    ram_bwren_d   = ram_bwren_q;
    ram_wraddrs_d = ram_wraddrs_q;
    ram_wrdata_d  = ram_wrdata_q;
    ram_rden_d    = |rd_gnt;
    ram_rdaddrs_d = ram_rdaddrs_q;
    rd_tag_d      = rd_gnt;
    rd_valid_d    = rd_tag_q;

    if (|wr_gnt) begin
      wr_ptr_d      = ~wr_sel;
      ram_bwren_d   = wr_be[wr_sel];
      ram_wraddrs_d = wr_addr[wr_sel];
      ram_wrdata_d  = wr_word[wr_sel];
    end

    if (|rd_gnt) begin
      rd_ptr_d      = ~rd_sel;
      ram_rdaddrs_d = rd_cand_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (rstb) begin
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_bwren_q   <= 8'h00;
      ram_wraddrs_q <= '0;
      ram_wrdata_q  <= 64'h0;
      ram_rden_q    <= 1'b0;
      ram_rdaddrs_q <= '0;
      rd_tag_q      <= 2'b00;
      rd_valid_q    <= 2'b00;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_wren_q    <= ram_wren_d;
      ram_bwren_q   <= ram_bwren_d;
      ram_wraddrs_q <= ram_wraddrs_d;
      ram_wrdata_q  <= ram_wrdata_d;
      ram_rden_q    <= ram_rden_d;
      ram_rdaddrs_q <= ram_rdaddrs_d;
      rd_tag_q      <= rd_tag_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign req_if.wr_gnt   = wr_gnt;
  assign req_if.rd_gnt   = rd_gnt;
  assign req_if.rd_valid = rd_valid_q;
  assign req_if.rd_data  = ram_rddata;

  assign ram_wren    = ram_wren_q;
  assign ram_bwren   = ram_bwren_q;
  assign ram_wraddrs = ram_wraddrs_q;
  assign ram_wrdata  = ram_wrdata_q;
  assign ram_rden    = ram_rden_q;
  assign ram_rdaddrs = ram_rdaddrs_q;

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_sdp_ram_port_arbiter                                    |
// | Description : Directed bench with RAM model and read-return scoreboard.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sdp_ram_port_arbiter;
  localparam int AW = 12;

  logic          CLK;
  logic          rstb;
  logic          ram_wren;
  logic [7:0]    ram_bwren;
  logic [AW-1:0] ram_wraddrs;
  logic [63:0]   ram_wrdata;
  logic          ram_rden;
  logic [AW-1:0] ram_rdaddrs;
  logic [63:0]   ram_rddata;

  sdp_ram_port_arbiter_if #(.ADDRS_WIDTH(AW)) bus ();

  sdp_ram_port_arbiter #(.ADDRS_WIDTH(AW)) dut (
    .CLK         (CLK),
    .rstb        (rstb),
    .req_if      (bus),
    .ram_wren    (ram_wren),
    .ram_bwren   (ram_bwren),
    .ram_wraddrs (ram_wraddrs),
    .ram_wrdata  (ram_wrdata),
    .ram_rden    (ram_rden),
    .ram_rdaddrs (ram_rdaddrs),
    .ram_rddata  (ram_rddata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Read-first RAM model: the read samples the array before the write lands
  logic [63:0] mem [int];
  always @(posedge CLK) begin
    logic [63:0] w;
    int a;
    if (ram_rden) ram_rddata <= mem.exists(int'(ram_rdaddrs)) ? mem[int'(ram_rdaddrs)] : 64'h0;
    if (ram_wren) begin
      a = int'(ram_wraddrs);
      w = mem.exists(a) ? mem[a] : 64'h0;
      for (int b = 0; b < 8; b++)
        if (ram_bwren[b]) w[b*8 +: 8] = ram_wrdata[b*8 +: 8];
      mem[a] = w;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations are pushed when a read is accepted and popped
  // when rd_valid shows up; the shadow memory tracks accepted writes.
  typedef struct {
    logic [1:0]  tag;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] shadow [int];

  function automatic logic [63:0] sh_rd(input int a);
    return shadow.exists(a) ? shadow[a] : 64'h0;
  endfunction

  always @(negedge CLK) begin
    exp_t        e;
    logic [63:0] w;
    int          r;
    int          a;
    if (bus.rd_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("rd_valid_unexpected", 64'(bus.rd_valid), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("sb_rd_tag", 64'(bus.rd_valid), 64'(e.tag));
        chk("sb_rd_data", bus.rd_data, e.data);
        chk("sb_rd_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rstb) begin
      sb.delete();
    end else begin
      if (|(bus.wr_gnt & bus.wr_req)) begin
        r = bus.wr_gnt[1] ? 1 : 0;
        a = int'(bus.wr_addrs[r*AW +: AW]);
        w = sh_rd(a);
        for (int b = 0; b < 8; b++)
          if (bus.wr_bwren[r*8+b]) w[b*8 +: 8] = bus.wr_data[r*64 + b*8 +: 8];
        shadow[a] = w;
      end
      if (|(bus.rd_gnt & bus.rd_req)) begin
        r = bus.rd_gnt[1] ? 1 : 0;
        e.tag  = bus.rd_gnt;
        e.data = sh_rd(int'(bus.rd_addrs[r*AW +: AW]));
        e.cyc  = cyc + 2;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    logic [AW-1:0] prev_addr;
    logic [1:0]    exp_g;

    rstb         = 1'b1;
    bus.wr_req   = 2'b11;
    bus.wr_addrs = {12'h201, 12'h200};
    bus.wr_data  = 128'h0;
    bus.wr_bwren = 16'h0000;
    bus.rd_req   = 2'b11;
    bus.rd_addrs = {12'h101, 12'h100};
    prev_addr    = '0;

    // Reset held 3 cycles with every request raised
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst_wr_gnt", 64'(bus.wr_gnt), 64'h0);
      chk("rst_rd_gnt", 64'(bus.rd_gnt), 64'h0);
      chk("rst_ram_wren", 64'(ram_wren), 64'h0);
      chk("rst_ram_rden", 64'(ram_rden), 64'h0);
      chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    end

    // Round-robin with both ports saturated
    nxt();
    rstb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp();
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_wr_gnt", 64'(bus.wr_gnt), 64'(exp_g));
      chk("rr_rd_gnt", 64'(bus.rd_gnt), 64'(exp_g));
      if (i > 0) chk("rr_ram_wraddrs", 64'(ram_wraddrs), 64'(prev_addr));
      prev_addr = (i % 2 == 0) ? 12'h200 : 12'h201;
      nxt();
    end
    bus.wr_req = 2'b00;
    bus.rd_req = 2'b00;
    smp();
    chk("rr_ram_wraddrs_last", 64'(ram_wraddrs), 64'(prev_addr));
    chk("rr_ram_wren_last", 64'(ram_wren), 64'h1);

    // Full-word write, then a single-byte overwrite, then readback
    nxt();
    bus.wr_req          = 2'b01;
    bus.wr_addrs[11:0]  = 12'h005;
    bus.wr_data[63:0]   = 64'h1122334455667788;
    bus.wr_bwren[7:0]   = 8'hFF;
    smp();
    chk("bw_wr_gnt0", 64'(bus.wr_gnt), 64'h1);
    nxt();
    bus.wr_req          = 2'b10;
    bus.wr_addrs[23:12] = 12'h005;
    bus.wr_data[127:64] = 64'hFFFFFFFFFFFFFFAA;
    bus.wr_bwren[15:8]  = 8'h01;
    smp();
    chk("bw_wr_gnt1", 64'(bus.wr_gnt), 64'h2);
    nxt();
    bus.wr_req          = 2'b00;
    bus.rd_req          = 2'b10;
    bus.rd_addrs[23:12] = 12'h005;
    smp();
    chk("bw_ram_bwren", 64'(ram_bwren), 64'h01);
    chk("bw_ram_wrdata", ram_wrdata, 64'hFFFFFFFFFFFFFFAA);
    chk("bw_rd_stall", 64'(bus.rd_gnt), 64'h0);
    nxt();
    smp();
    chk("bw_rd_gnt", 64'(bus.rd_gnt), 64'h2);
    nxt();
    bus.rd_req = 2'b00;
    smp();
    nxt();
    smp();
    chk("bw_rd_valid", 64'(bus.rd_valid), 64'h2);
    chk("bw_rd_data", bus.rd_data, 64'h11223344556677AA);

    // Same-cycle write and read to one address
    nxt();
    bus.wr_req         = 2'b01;
    bus.wr_addrs[11:0] = 12'h0A0;
    bus.wr_data[63:0]  = 64'hDEAD;
    bus.wr_bwren[7:0]  = 8'hFF;
    bus.rd_req         = 2'b01;
    bus.rd_addrs[11:0] = 12'h0A0;
    smp();
    chk("hz_wr_gnt", 64'(bus.wr_gnt), 64'h1);
    chk("hz_rd_stall0", 64'(bus.rd_gnt), 64'h0);
    nxt();
    bus.wr_req = 2'b00;
    smp();
    chk("hz_rd_stall1", 64'(bus.rd_gnt), 64'h0);
    nxt();
    smp();
    chk("hz_rd_gnt", 64'(bus.rd_gnt), 64'h1);
    nxt();
    bus.rd_req = 2'b00;
    smp();
    nxt();
    smp();
    chk("hz_rd_valid", 64'(bus.rd_valid), 64'h1);
    chk("hz_rd_data", bus.rd_data, 64'hDEAD);

    // Different addresses in the same cycle proceed together
    nxt();
    bus.wr_req         = 2'b01;
    bus.wr_addrs[11:0] = 12'h0B0;
    bus.wr_data[63:0]  = 64'hBEEF;
    bus.rd_req         = 2'b01;
    bus.rd_addrs[11:0] = 12'h0A1;
    smp();
    chk("nohz_wr_gnt", 64'(bus.wr_gnt), 64'h1);
    chk("nohz_rd_gnt", 64'(bus.rd_gnt), 64'h1);

    // Preload for the pipelined read test
    nxt();
    bus.rd_req         = 2'b00;
    bus.wr_addrs[11:0] = 12'h001;
    bus.wr_data[63:0]  = 64'h10;
    smp();
    chk("pre_wr_gnt_a", 64'(bus.wr_gnt), 64'h1);
    nxt();
    bus.wr_addrs[11:0] = 12'h002;
    bus.wr_data[63:0]  = 64'h20;
    smp();
    chk("pre_wr_gnt_b", 64'(bus.wr_gnt), 64'h1);

    // Reset the cycle after a read grant: that read must never return
    nxt();
    bus.wr_req         = 2'b00;
    bus.rd_req         = 2'b01;
    bus.rd_addrs[11:0] = 12'h001;
    smp();
    chk("rr_mid_rd_gnt", 64'(bus.rd_gnt), 64'h1);
    nxt();
    bus.rd_req = 2'b00;
    rstb       = 1'b1;
    smp();
    nxt();
    smp();
    chk("mid_rst_rd_valid", 64'(bus.rd_valid), 64'h0);

    // Pipelined alternating reads after reset release
    nxt();
    rstb         = 1'b0;
    bus.rd_req   = 2'b11;
    bus.rd_addrs = {12'h002, 12'h001};
    for (int k = 0; k < 6; k++) begin
      smp();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      if (k < 4) chk("pipe_rd_gnt", 64'(bus.rd_gnt), 64'(exp_g));
      if (k < 2) chk("pipe_no_stale_valid", 64'(bus.rd_valid), 64'h0);
      if (k >= 2) begin
        chk("pipe_rd_valid", 64'(bus.rd_valid), 64'(exp_g));
        chk("pipe_rd_data", bus.rd_data, (k % 2 == 0) ? 64'h10 : 64'h20);
      end
      nxt();
      if (k == 3) bus.rd_req = 2'b00;
    end

    for (int k = 0; k < 3; k++) smp();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
